// File: rtl/cpu_types_pkg.sv
// Shared datapath types for the front end: words, opcodes, fetch FSM state and FIFO entry.
package cpu_types_pkg;

    localparam int unsigned WORD_W   = 32;
    localparam int unsigned OPCODE_W = 6;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [OPCODE_W-1:0] {
        RTYPE = 6'h00,
        J     = 6'h02,
        JAL   = 6'h03,
        BEQ   = 6'h04,
        BNE   = 6'h05,
        ADDIU = 6'h09,
        LW    = 6'h23,
        SW    = 6'h2B,
        HALT  = 6'h3F
    } opcode_t;

    typedef enum logic {
        FETCH  = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    typedef struct packed {
        word_t instr;
        word_t laddr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Synchronous skid FIFO of fetch entries; registered head, no bypass, flush empties it.
module fetch_buffer
    import cpu_types_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_data,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = empty ? '0 : mem_q[rptr_q];

    // A pop in the same cycle frees the slot, so a push into a full FIFO is accepted.
    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        mem_d   = mem_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wptr_q] = push_data;
                wptr_d        = wptr_q + AW'(1);
            end
            if (do_pop) begin
                rptr_d = rptr_q + AW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, imem requests, skid buffer, redirect and HALT handling.
// Optional perf counters (perf_fetched, perf_stalled) are enabled with FETCH_PERF_EN.
module fetch_unit
    import cpu_types_pkg::*;
#(
    parameter word_t       PC_INIT   = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic    CLK,
    input  logic    RST,
`ifdef FETCH_PERF_EN
    output word_t   perf_fetched,
    output word_t   perf_stalled,
`endif
    output logic    imemREN,
    output word_t   imemaddr,
    input  word_t   imemload,
    input  logic    ihit,
    input  logic    stall,
    input  logic    redirect,
    input  word_t   redirect_pc,
    output word_t   iloadi,
    output word_t   laddri,
    output opcode_t fetch_opcodei,
    output logic    fetch_en,
    output logic    flush
);

    fetch_state_t state_q, state_d;
    word_t        pc_q, pc_d;
    word_t        pc_plus4;
    logic         buf_full;
    logic         buf_empty;
    logic         push;
    logic         pop;
    fetch_entry_t buf_head;
    fetch_entry_t push_entry;

    assign pc_plus4   = pc_q + 32'd4;
    assign push_entry = '{instr: imemload, laddr: pc_plus4};

    // Next-state, PC update and handshake outputs; redirect overrides everything but reset.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pop     = !RST && !buf_empty && !stall && !redirect;
        imemREN = !RST && (state_q == FETCH) && (!buf_full || pop);
        push    = imemREN && ihit && !redirect;
        if (redirect) begin
            state_d = FETCH;
            pc_d    = redirect_pc;
        end else if (push) begin
            if (imemload[31:26] == HALT) begin
                state_d = HALTED;
            end else begin
                pc_d = pc_plus4;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= FETCH;
            pc_q    <= PC_INIT;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk       (CLK),
        .rst       (RST),
        .push      (push),
        .pop       (pop),
        .flush     (redirect),
        .push_data (push_entry),
        .full      (buf_full),
        .empty     (buf_empty),
        .head      (buf_head)
    );

    assign imemaddr      = RST ? '0 : {pc_q[31:2], 2'b00};
    assign fetch_en      = pop;
    assign flush         = !RST && redirect;
    assign iloadi        = RST ? '0 : buf_head.instr;
    assign laddri        = RST ? '0 : buf_head.laddr;
    assign fetch_opcodei = opcode_t'(iloadi[31:26]);

`ifdef FETCH_PERF_EN
    word_t perf_fetched_q, perf_fetched_d;
    word_t perf_stalled_q, perf_stalled_d;

    // Saturating event counters.
    always_comb begin
        perf_fetched_d = perf_fetched_q;
        perf_stalled_d = perf_stalled_q;
        if (push && (perf_fetched_q != '1)) begin
            perf_fetched_d = perf_fetched_q + 32'd1;
        end
        if (imemREN && !ihit && (perf_stalled_q != '1)) begin
            perf_stalled_d = perf_stalled_q + 32'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            perf_fetched_q <= '0;
            perf_stalled_q <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_stalled_q <= perf_stalled_d;
        end
    end

    assign perf_fetched = RST ? '0 : perf_fetched_q;
    assign perf_stalled = RST ? '0 : perf_stalled_q;
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Front end of the pipelined datapath.
- Owns the PC and issues instruction reads to the instruction memory/icache.
- Buffers returned words in a small skid FIFO, then drives the instruction, link address and opcode into the fetch latch (the `fetch_if` input side) with `fetch_en`/`flush`.
- Handles branch/jump redirects and stops fetching after a HALT.

Parameters:
- PC_INIT, 32'h0000_0000, PC value loaded on reset.
- BUF_DEPTH, 2, skid-FIFO entries (power of two, at least 2).

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  synchronous reset, active-high
- imemREN  out  1  instruction read request
- imemaddr  out  32  word-aligned fetch address (PC)
- imemload  in  32  instruction word returned from memory
- ihit  in  1  imemload is valid for the current imemaddr this cycle
- stall  in  1  fetch latch cannot accept an instruction this cycle
- redirect  in  1  control-flow change resolved downstream
- redirect_pc  in  32  target PC for the redirect
- iloadi  out  32  instruction to the fetch latch
- laddri  out  32  link address (PC+4 of that instruction) to the fetch latch
- fetch_opcodei  out  opcode_t  iloadi[31:26]
- fetch_en  out  1  fetch latch loads iloadi/laddri/fetch_opcodei this cycle
- flush  out  1  fetch latch clears to a bubble this cycle

Behaviour:
- Clock and reset:
  - One clock, CLK. RST is synchronous and active-high.
  - While RST is high, all outputs are 0.
  - On the first cycle after reset, PC = PC_INIT, the FIFO is empty and the state is FETCH.
- FSM has two states: FETCH and HALTED.
- FETCH state:
  - imemREN = 1 when the FIFO is not full; imemaddr = PC.
  - On ihit with imemREN high: push {imemload, PC+4} and set PC <= PC+4.
  - If imemload[31:26] == HALT, go to HALTED and hold PC.
  - FIFO full: imemREN = 0, PC holds, and ihit is ignored.
- HALTED state:
  - imemREN = 0 and no pushes.
  - Buffered entries, including the HALT word, still drain.
  - Only redirect or RST leaves this state.
- Output side:
  - fetch_en = FIFO not empty && !stall && !redirect.
  - iloadi/laddri/fetch_opcodei always show the FIFO head, and are 0 when the FIFO is empty.
  - An entry pops on the cycle fetch_en is high.
- Push and pop in the same cycle are allowed, including when the FIFO is full: a pop frees the slot in the same cycle, so imemREN may be 1.
- Redirect has the highest priority:
  - flush = redirect (combinational, one cycle per assertion).
  - The FIFO empties, PC <= redirect_pc, and the state becomes FETCH (also from HALTED).
  - Any ihit in the same cycle is discarded, and fetch_en = 0 that cycle.
- stall together with redirect: the redirect wins; flush = 1 and fetch_en = 0.
- Address arithmetic:
  - PC+4 is a 32-bit add that wraps; 32'hFFFF_FFFC + 4 = 0.
  - imemaddr[1:0] is forced to 0.
- Latency: in the best case an instruction appears at the latch on the cycle after its ihit. Back-to-back ihits with no stall sustain one instruction per cycle.

Optional Feature:
- Macro: FETCH_PERF_EN.
- When defined:
  - Adds two 32-bit outputs, perf_fetched and perf_stalled, both cleared by RST.
  - perf_fetched counts cycles with a push.
  - perf_stalled counts cycles with imemREN high and ihit low.
  - Both counters saturate at 32'hFFFF_FFFF.
- When undefined: no ports and no logic are added; behaviour is otherwise identical.

Decomposition:
- cpu_types_pkg holds: word_t, opcode_t (with HALT), a new fetch_state_t enum {FETCH, HALTED}, and a packed fetch_entry_t {word_t instr; word_t laddr}.
- Sub-module fetch_buffer: a parameterised synchronous FIFO of fetch_entry_t with push, pop, flush, full, empty and head. It has no bypass; the head is registered.

Test Plan:
- Reset with PC_INIT = 32'h100 and ihit held at 1, stall = 0:
  - imemaddr = 100, 104, 108 on consecutive cycles.
  - fetch_en is high from the 2nd cycle, with laddri = 104, 108, …
- stall held high for 4 cycles with ihit = 1:
  - Exactly 2 pushes, then imemREN = 0 and PC holds at base+8.
  - On release, entries emerge in order with none lost.
- redirect with redirect_pc = 32'h400 in the same cycle as an ihit:
  - flush = 1 and fetch_en = 0 that cycle.
  - The FIFO empties.
  - The next imemaddr = 400 and the discarded word never appears.
- HALT word returned at PC 32'h20:
  - imemREN goes low and stays low.
  - The HALT drains to the latch with laddri = 24.
  - A later redirect to 32'h40 resumes fetching at 40.
- PC at 32'hFFFF_FFFC with ihit: laddri = 0 and the next imemaddr = 0.
- RST asserted mid-stream with the FIFO full: all outputs are 0 that cycle; next cycle imemaddr = PC_INIT with the FIFO empty.
